// File: rtl/dff_arb_pkg.sv
// Shared types and the round-robin pick helper for the shared D-register arbiter.
package dff_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, SETTLE} arb_state_t;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned MAX_REQ = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rr_pick_t;

    // Scan starts at ptr and wraps modulo n, so non-power-of-2 counts stay fair.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
        rr_pick_t    r;
        int unsigned cand;
        r = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= n) begin
                cand = cand - n;
            end
            if ((i < n) && !r.valid && req[cand[2:0]]) begin
                r.valid = 1'b1;
                r.idx   = cand[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dff_share_arbiter_if.sv
// Requester/consumer bundle of the shared register: requests and data in, grant and stored value out.
interface dff_share_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned OW = $clog2(N_REQ);

    logic [N_REQ-1:0]           req;
    logic [N_REQ*WIDTH-1:0]     wdata;
    logic [N_REQ-1:0]           gnt;
    logic [WIDTH-1:0]           q;
    logic [WIDTH-1:0]           qbar;
    logic [OW-1:0]              owner;
    logic                       busy;
    logic [dff_arb_pkg::CNT_W-1:0] load_cnt;

    modport master (output req, wdata, input gnt, q, qbar, owner, busy, load_cnt);
    modport slave  (input req, wdata, output gnt, q, qbar, owner, busy, load_cnt);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority select over N_REQ requests starting at ptr.
module rr_arbiter
    import dff_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned OW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [OW-1:0]    i_ptr,
    output logic [OW-1:0]    o_winner,
    output logic             o_any
);

    logic [MAX_REQ-1:0] w_req_ext;
    logic [2:0]         w_ptr_ext;
    rr_pick_t           w_pick;

    assign w_req_ext = MAX_REQ'(i_req);
    assign w_ptr_ext = 3'(i_ptr);
    assign w_pick    = rr_pick(w_req_ext, w_ptr_ext, N_REQ);
    assign o_winner  = OW'(w_pick.idx);
    assign o_any     = w_pick.valid;

endmodule

// File: rtl/dff_share_arbiter.sv
// Round-robin write arbiter owning one shared WIDTH-bit register; each load is followed
// by a SETTLE-cycle hold before the next grant.
module dff_share_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    dff_share_arbiter_if.slave  bus
);
    import dff_arb_pkg::*;

    localparam int unsigned OW = $clog2(N_REQ);

    if ((N_REQ < 2) || (N_REQ > MAX_REQ)) begin : g_bad_nreq
        $error("dff_share_arbiter: N_REQ must be in 2..8");
    end
    if (SETTLE > 15) begin : g_bad_settle
        $error("dff_share_arbiter: SETTLE must be in 0..15");
    end

    arb_state_t       r_state;
    logic [OW-1:0]    r_ptr;
    logic [OW-1:0]    r_win;
    logic [OW-1:0]    r_owner;
    logic [N_REQ-1:0] r_gnt;
    logic [WIDTH-1:0] r_q;
    logic             r_busy;
    logic [3:0]       r_settle_cnt;
    logic [CNT_W-1:0] r_load_cnt;

    logic [OW-1:0]    w_win;
    logic             w_any;
    logic [WIDTH-1:0] w_sel_data;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    // Winner is latched on entry to GRANT, so a req drop during GRANT still loads.
    assign w_sel_data = bus.wdata[r_win*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_win        <= '0;
            r_owner      <= '0;
            r_gnt        <= '0;
            r_q          <= '0;
            r_busy       <= 1'b0;
            r_settle_cnt <= '0;
            r_load_cnt   <= '0;
        end else begin
            r_gnt <= '0;
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win   <= w_win;
                        r_gnt   <= N_REQ'(1) << w_win;
                        r_busy  <= 1'b1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    r_q          <= w_sel_data;
                    r_owner      <= r_win;
                    r_load_cnt   <= r_load_cnt + 1'b1;
                    r_ptr        <= (r_win == OW'(N_REQ - 1)) ? '0 : r_win + 1'b1;
                    r_settle_cnt <= '0;
                    if (SETTLE > 0) begin
                        r_state <= dff_arb_pkg::SETTLE;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                dff_arb_pkg::SETTLE: begin
                    if (r_settle_cnt == 4'(SETTLE - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.q        = r_q;
    assign bus.qbar     = ~r_q;
    assign bus.owner    = r_owner;
    assign bus.busy     = r_busy;
    assign bus.load_cnt = r_load_cnt;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter: timeline model checked every cycle plus literal expectations.
module tb_dff_share_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned SETTLE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [WIDTH-1:0] wd [N_REQ];

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int gl_idx [$];
    int gl_cyc [$];

    dff_share_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    dff_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.wdata = '0;
        for (int i = 0; i < N_REQ; i++) bus.wdata[i*WIDTH +: WIDTH] = wd[i];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: a load happens one edge after a grant, then the register is
    // held for SETTLE edges; arbitration resumes on the edge after that.
    int         m_cyc = 0, m_gw = -1, m_idle_from = -1, m_ptr = 0, m_owner = 0, m_cnt = 0;
    logic [7:0] m_q = '0;
    logic       m_busy = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_gw = -1; m_idle_from = -1; m_ptr = 0;
            m_owner = 0; m_cnt = 0; m_q = '0; m_busy = 1'b0;
        end else begin
            if (m_gw >= 0) begin
                m_q         = wd[m_gw];
                m_owner     = m_gw;
                m_cnt       = (m_cnt + 1) % 65536;
                m_ptr       = (m_gw + 1) % N_REQ;
                m_idle_from = m_cyc + SETTLE;
                m_gw        = -1;
            end else if (m_cyc > m_idle_from && bus.req != 0) begin
                for (int k = 0; k < N_REQ; k++)
                    if (m_gw < 0 && bus.req[(m_ptr + k) % N_REQ]) m_gw = (m_ptr + k) % N_REQ;
            end
            m_busy = (m_gw >= 0) || (m_cyc < m_idle_from);
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        logic [N_REQ-1:0] e_gnt;
        logic [WIDTH-1:0] e_qb;
        ncyc++;
        if (!rst) begin
            e_gnt = (m_gw >= 0) ? (N_REQ'(1) << m_gw) : '0;
            e_qb  = ~m_q;
            chk("gnt", 32'(bus.gnt), 32'(e_gnt));
            chk("busy", 32'(bus.busy), 32'(m_busy));
            chk("q", 32'(bus.q), 32'(m_q));
            chk("qbar", 32'(bus.qbar), 32'(e_qb));
            chk("owner", 32'(bus.owner), 32'(m_owner));
            chk("load_cnt", 32'(bus.load_cnt), 32'(m_cnt));
            for (int i = 0; i < N_REQ; i++)
                if (bus.gnt[i]) begin gl_idx.push_back(i); gl_cyc.push_back(ncyc); end
        end
    end

    // Requesters drop req once they observe their grant.
    task automatic tick();
        @(negedge clk);
        bus.req = bus.req & ~bus.gnt;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60; n++) begin
            tick();
            if (!bus.busy && bus.gnt == 0 && bus.req == 0) return;
        end
        chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_gnt(input int idx);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (bus.gnt[idx]) return;
        end
        chk("wait_gnt_timeout", 32'd1, 32'd0);
    endtask

    task automatic clear_log();
        gl_idx.delete();
        gl_cyc.delete();
    endtask

    initial begin
        int busy_n, gnt_n;
        bus.req = '0;
        for (int i = 0; i < N_REQ; i++) wd[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-grant
        tick();
        wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
        bus.req = 4'b1111;
        wait_gnt(0);
        #2 rst = 1'b1;
        #2;
        chk("rst_q", 32'(bus.q), 32'h00);
        chk("rst_qbar", 32'(bus.qbar), 32'hFF);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_load_cnt", 32'(bus.load_cnt), 32'h0);
        bus.req = '0;
        #3 rst = 1'b0;

        // Full contention from ptr=0
        tick();
        clear_log();
        bus.req = 4'b1111;
        wait_idle();
        chk("cont_n", 32'(gl_idx.size()), 32'd4);
        if (gl_idx.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("cont_order", 32'(gl_idx[i]), 32'(i));
            for (int i = 1; i < 4; i++) chk("cont_spacing", 32'(gl_cyc[i] - gl_cyc[i-1]), 32'd4);
        end
        chk("cont_q", 32'(bus.q), 32'h44);
        chk("cont_load_cnt", 32'(bus.load_cnt), 32'd4);

        // Single requester
        tick();
        wd[2] = 8'hA5;
        bus.req = 4'b0100;
        busy_n = 0; gnt_n = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (bus.busy) busy_n++;
            if (bus.gnt == 4'b0100) gnt_n++;
        end
        chk("single_gnt_cycles", 32'(gnt_n), 32'd1);
        chk("single_busy_cycles", 32'(busy_n), 32'd3);
        chk("single_q", 32'(bus.q), 32'hA5);
        chk("single_qbar", 32'(bus.qbar), 32'h5A);
        chk("single_owner", 32'(bus.owner), 32'd2);
        chk("single_load_cnt", 32'(bus.load_cnt), 32'd5);

        // Pointer wrap: ptr=3 now
        clear_log();
        wd[3] = 8'h3A; wd[0] = 8'h0B;
        bus.req = 4'b1001;
        wait_idle();
        chk("wrap_n", 32'(gl_idx.size()), 32'd2);
        if (gl_idx.size() == 2) begin
            chk("wrap_first", 32'(gl_idx[0]), 32'd3);
            chk("wrap_second", 32'(gl_idx[1]), 32'd0);
        end
        chk("wrap_q", 32'(bus.q), 32'h0B);
        chk("wrap_load_cnt", 32'(bus.load_cnt), 32'd7);

        // Request raised during SETTLE is held off until IDLE
        tick();
        clear_log();
        wd[2] = 8'hC3; wd[1] = 8'hD7;
        bus.req = 4'b0100;
        wait_gnt(2);
        tick();
        bus.req[1] = 1'b1;
        wait_idle();
        chk("settle_n", 32'(gl_idx.size()), 32'd2);
        if (gl_idx.size() == 2) begin
            chk("settle_order", 32'(gl_idx[1]), 32'd1);
            chk("settle_gap", 32'(gl_cyc[1] - gl_cyc[0]), 32'd4);
        end
        chk("settle_q", 32'(bus.q), 32'hD7);

        // req[0] drops in its grant cycle; load still completes
        tick();
        wd[0] = 8'h5C;
        bus.req = 4'b0001;
        wait_gnt(0);
        bus.req[0] = 1'b0;
        wait_idle();
        chk("drop_q", 32'(bus.q), 32'h5C);
        chk("drop_owner", 32'(bus.owner), 32'd0);
        chk("drop_load_cnt", 32'(bus.load_cnt), 32'd10);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
